// File: rtl/imem_loader.sv
// Purpose: assembles a checksummed byte stream into little-endian words and writes them into instruction memory.
// Latency: the write pulse appears one cycle after the byte that fills lane 3 is accepted.
// Backpressure: in_ready depends only on the state. It is high while the loader expects count, data or checksum bytes. Stalls of any length are tolerated.
`timescale 1ns/1ps

module imem_loader #(
    parameter int unsigned ADDR_W    = 8,
    parameter int unsigned BASE_ADDR = 0,
    parameter int unsigned MAX_WORDS = 64
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              in_valid,
    input  logic [7:0]        in_data,
    output logic              in_ready,
    output logic              imem_we,
    output logic [ADDR_W-1:0] imem_waddr,
    output logic [31:0]       imem_wdata,
    output logic              cpu_hold,
    output logic              done,
    output logic              error,
    output logic [ADDR_W-2:0] words_written
);

    localparam int unsigned WW_W = ADDR_W - 1;
    localparam logic [ADDR_W-1:0] BASE_A = BASE_ADDR[ADDR_W-1:0];

    typedef enum logic [2:0] {
        S_COUNT = 3'd0,
        S_DATA  = 3'd1,
        S_CHECK = 3'd2,
        S_DONE  = 3'd3,
        S_ERROR = 3'd4
    } state_t;

    state_t            state;
    logic [7:0]        n_words;    // word count announced by the stream header
    logic [1:0]        byte_idx;   // lane of the next data byte
    logic [7:0]        xor_acc;    // running XOR of every data byte seen
    logic [23:0]       lane_buf;   // lanes 0..2 of the word being assembled

    logic              accepting;
    logic              xfer;
    logic [WW_W-1:0]   ww_inc;
    logic [ADDR_W-1:0] word_off;
    logic              last_word;

    // Byte acceptance is a pure state decode. It is held low while reset is asserted.
    assign accepting = (state == S_COUNT) || (state == S_DATA) || (state == S_CHECK);
    assign in_ready  = rst_n & accepting;
    assign xfer      = in_valid & in_ready;

    // Byte offset of the word being completed, 4*words_written, wrapping within the address space.
    assign word_off  = {words_written[ADDR_W-3:0], 2'b00};
    assign ww_inc    = words_written + 1'b1;
    assign last_word = (32'(ww_inc) == 32'(n_words));

    // Loader FSM together with the datapath registers it owns.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= S_COUNT;
            n_words       <= 8'd0;
            byte_idx      <= 2'd0;
            xor_acc       <= 8'd0;
            lane_buf      <= 24'd0;
            imem_we       <= 1'b0;
            imem_waddr    <= BASE_A;
            imem_wdata    <= 32'd0;
            cpu_hold      <= 1'b1;
            done          <= 1'b0;
            error         <= 1'b0;
            words_written <= '0;
        end else begin
            // Write enable is a single-cycle pulse. Only the lane-3 byte raises it.
            imem_we <= 1'b0;

            case (state)
                S_COUNT: begin
                    if (xfer) begin
                        n_words <= in_data;
                        if (32'(in_data) > MAX_WORDS) begin
                            state <= S_ERROR;
                            error <= 1'b1;
                        end else if (in_data == 8'd0) begin
                            // An empty image still needs its checksum, which must be 0x00.
                            state <= S_CHECK;
                        end else begin
                            state <= S_DATA;
                        end
                    end
                end

                S_DATA: begin
                    if (xfer) begin
                        xor_acc  <= xor_acc ^ in_data;
                        byte_idx <= byte_idx + 2'd1;
                        if (byte_idx == 2'd3) begin
                            imem_we       <= 1'b1;
                            imem_wdata    <= {in_data, lane_buf};
                            imem_waddr    <= BASE_A + word_off;
                            words_written <= ww_inc;
                            // Once the last word is complete, the checksum byte comes next.
                            if (last_word) begin
                                state <= S_CHECK;
                            end
                        end else begin
                            lane_buf[{byte_idx, 3'b000} +: 8] <= in_data;
                        end
                    end
                end

                S_CHECK: begin
                    if (xfer) begin
                        if (in_data == xor_acc) begin
                            state    <= S_DONE;
                            done     <= 1'b1;
                            cpu_hold <= 1'b0;
                        end else begin
                            state <= S_ERROR;
                            error <= 1'b1;
                        end
                    end
                end

                S_DONE, S_ERROR: begin
                    // Terminal states. Only start begins a new load. Words already written stay in memory.
                    if (start) begin
                        state         <= S_COUNT;
                        done          <= 1'b0;
                        error         <= 1'b0;
                        cpu_hold      <= 1'b1;
                        words_written <= '0;
                        byte_idx      <= 2'd0;
                        xor_acc       <= 8'd0;
                        lane_buf      <= 24'd0;
                        imem_waddr    <= BASE_A;
                    end
                end

                default: begin
                    // An unreachable encoding parks the loader in a safe, CPU-holding state.
                    state    <= S_ERROR;
                    done     <= 1'b0;
                    error    <= 1'b1;
                    cpu_hold <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_imem_loader.sv
// Purpose: directed and random loads of imem_loader, checked against a stream-level reference model.
// Latency: each write pulse is expected exactly one cycle after its lane-3 byte is accepted.
// Backpressure: the driver holds each byte until in_ready and optionally inserts random stalls.
`timescale 1ns/1ps

module tb_imem_loader;

    localparam int ADDR_W = 8;
    localparam int BASE   = 0;
    localparam int MAXW   = 64;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              start;
    logic              in_valid;
    logic [7:0]        in_data;
    logic              in_ready;
    logic              imem_we;
    logic [ADDR_W-1:0] imem_waddr;
    logic [31:0]       imem_wdata;
    logic              cpu_hold;
    logic              done;
    logic              error;
    logic [ADDR_W-2:0] words_written;

    int passed = 0;
    int total  = 0;
    int cyc    = 0;
    int exp_we_cyc = -1;

    logic [7:0]  stream[$];
    logic [7:0]  got_addr[$];
    logic [31:0] got_data[$];
    int          got_base;

    imem_loader #(.ADDR_W(ADDR_W), .BASE_ADDR(BASE), .MAX_WORDS(MAXW)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .in_valid(in_valid), .in_data(in_data),
        .in_ready(in_ready), .imem_we(imem_we), .imem_waddr(imem_waddr), .imem_wdata(imem_wdata),
        .cpu_hold(cpu_hold), .done(done), .error(error), .words_written(words_written)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        assert (got === exp) passed++;
        else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    // Monitor: the write pulse must land exactly in the cycle after a lane-3 byte is accepted, and never elsewhere.
    always @(negedge clk) begin
        chk("we_timing", 32'(imem_we), 32'(cyc == exp_we_cyc));
        chk("done_err_excl", 32'(done & error), 32'd0);
        if (imem_we) begin
            got_addr.push_back(imem_waddr);
            got_data.push_back(imem_wdata);
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, observed timeout expected completion");
        $fatal(1, "watchdog");
    end

    task automatic send(input logic [7:0] b, input bit l3, input bit stall);
        int t;
        if (stall && ($urandom_range(0, 1) == 1)) begin
            in_valid = 1'b0;
            repeat ($urandom_range(1, 3)) @(posedge clk);
            #1;
        end
        in_valid = 1'b1;
        in_data  = b;
        t = 0;
        @(negedge clk);
        while (!in_ready && t < 50) begin
            t++;
            @(negedge clk);
        end
        if (!in_ready) begin
            chk("hs_timeout", 32'(in_ready), 32'd1);
            in_valid = 1'b0;
            return;
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        if (l3) exp_we_cyc = cyc;
    endtask

    function automatic bit is_lane3(input int i, input int n);
        return (n <= MAXW) && (i >= 1) && (i <= 4 * n) && (((i - 1) % 4) == 3);
    endfunction

    task automatic run_stream(input bit stall);
        int n;
        n = int'(stream[0]);
        got_base = got_addr.size();
        for (int i = 0; i < stream.size(); i++) send(stream[i], is_lane3(i, n), stall);
        repeat (2) @(posedge clk);
        #1;
    endtask

    task automatic gen_stream(input int n, input bit corrupt);
        logic [7:0] x;
        logic [7:0] b;
        stream.delete();
        stream.push_back(8'(n));
        if (n <= MAXW) begin
            x = 8'd0;
            for (int i = 0; i < 4 * n; i++) begin
                b = 8'($urandom_range(0, 255));
                stream.push_back(b);
                x = x ^ b;
            end
            stream.push_back(corrupt ? (x ^ 8'($urandom_range(1, 255))) : x);
        end
    endtask

    // Reference model: what a correct loader must have produced from the stream just sent.
    task automatic check_model();
        int n;
        int nw;
        logic [7:0] x;
        bit ok;
        n  = int'(stream[0]);
        nw = got_addr.size() - got_base;
        if (n > MAXW) begin
            chk("ovf_writes", 32'(nw), 32'd0);
            chk("ovf_error", 32'(error), 32'd1);
            chk("ovf_done", 32'(done), 32'd0);
            chk("ovf_hold", 32'(cpu_hold), 32'd1);
            chk("ovf_ready", 32'(in_ready), 32'd0);
        end else begin
            x = 8'd0;
            for (int i = 1; i <= 4 * n; i++) x = x ^ stream[i];
            ok = (stream[4 * n + 1] == x);
            chk("wr_count", 32'(nw), 32'(n));
            for (int k = 0; k < n && k < nw; k++) begin
                chk("wr_addr", 32'(got_addr[got_base + k]), 32'((BASE + 4 * k) % 256));
                chk("wr_data", got_data[got_base + k],
                    {stream[4 * k + 4], stream[4 * k + 3], stream[4 * k + 2], stream[4 * k + 1]});
            end
            chk("words_written", 32'(words_written), 32'(n));
            chk("done", 32'(done), 32'(ok));
            chk("error", 32'(error), 32'(!ok));
            chk("cpu_hold", 32'(cpu_hold), 32'(!ok));
            chk("ready_end", 32'(in_ready), 32'd0);
        end
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        chk("st_hold", 32'(cpu_hold), 32'd1);
        chk("st_done", 32'(done), 32'd0);
        chk("st_error", 32'(error), 32'd0);
        chk("st_ww", 32'(words_written), 32'd0);
        chk("st_waddr", 32'(imem_waddr), 32'(BASE));
        chk("st_ready", 32'(in_ready), 32'd1);
    endtask

    task automatic chk_reset_vals();
        chk("rst_ready", 32'(in_ready), 32'd0);
        chk("rst_we", 32'(imem_we), 32'd0);
        chk("rst_waddr", 32'(imem_waddr), 32'(BASE));
        chk("rst_wdata", imem_wdata, 32'd0);
        chk("rst_hold", 32'(cpu_hold), 32'd1);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_error", 32'(error), 32'd0);
        chk("rst_ww", 32'(words_written), 32'd0);
    endtask

    initial begin
        int n;
        rst_n = 1'b0; start = 1'b0; in_valid = 1'b0; in_data = 8'd0;
        repeat (3) @(posedge clk);
        #1;
        chk_reset_vals();
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        chk("ready_after_rst", 32'(in_ready), 32'd1);

        // Two addi instructions; the checksum is the XOR of the 8 data bytes, which is 0x20.
        stream = '{8'h02, 8'h13, 8'h05, 8'h00, 8'h00, 8'h93, 8'h05, 8'hA0, 8'h00, 8'h20};
        run_stream(1'b0);
        check_model();
        chk("addi0_data", got_data[got_base], 32'h0000_0513);
        chk("addi1_data", got_data[got_base + 1], 32'h00A0_0593);
        chk("addi1_addr", 32'(got_addr[got_base + 1]), 32'h04);

        // Bad checksum, then recovery with start.
        pulse_start();
        stream[9] = 8'h21;
        run_stream(1'b0);
        check_model();
        pulse_start();
        stream[9] = 8'h20;
        run_stream(1'b1);
        check_model();

        // A count above the maximum is rejected immediately.
        pulse_start();
        gen_stream(65, 1'b0);
        run_stream(1'b0);
        check_model();

        // Empty image: checksum 0x00 loads; 0x01 fails.
        pulse_start();
        stream = '{8'h00, 8'h00};
        run_stream(1'b0);
        check_model();
        pulse_start();
        stream = '{8'h00, 8'h01};
        run_stream(1'b0);
        check_model();

        // Three words with and without stalls must produce identical writes.
        pulse_start();
        gen_stream(3, 1'b0);
        run_stream(1'b0);
        check_model();
        pulse_start();
        run_stream(1'b1);
        check_model();

        // Largest image, filling the whole address space.
        pulse_start();
        gen_stream(MAXW, 1'b0);
        run_stream(1'b1);
        check_model();
        chk("max_last_addr", 32'(got_addr[got_addr.size() - 1]), 32'hFC);

        // Random loads with random corruption and stalls.
        for (int r = 0; r < 6; r++) begin
            pulse_start();
            n = $urandom_range(1, 6);
            gen_stream(n, 1'($urandom_range(0, 1)));
            run_stream(1'($urandom_range(0, 1)));
            check_model();
        end

        // Reset after 6 data bytes of a 2-word load.
        pulse_start();
        gen_stream(2, 1'b0);
        got_base = got_addr.size();
        for (int i = 0; i < 7; i++) send(stream[i], is_lane3(i, 2), 1'b0);
        rst_n = 1'b0;
        #1;
        chk_reset_vals();
        chk("partial_writes", 32'(got_addr.size() - got_base), 32'd1);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        gen_stream(2, 1'b0);
        run_stream(1'b1);
        check_model();

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/imem_loader.md
Name: imem_loader

Overview:
Program loader that writes the instruction memory. It is the writer side of the instruction-fetch read port: it takes a byte stream through a valid/ready handshake and assembles the bytes into little-endian 32-bit instruction words. Each word is written to consecutive word-aligned byte addresses on the instruction memory write port. It holds the CPU (gating PC_Write/IF_ID_Write) until a complete, checksum-verified image is loaded.

Parameters:
ADDR_W, 8, byte-address width of instruction memory (matches 8-bit PC)
BASE_ADDR, 0, byte address of first word written; multiple of 4
MAX_WORDS, 64, largest accepted word count (2^ADDR_W / 4)

Ports:
clk  input  1  system clock, rising edge
rst_n  input  1  asynchronous active-low reset
start  input  1  single-cycle pulse; restarts loading from DONE or ERROR
in_valid  input  1  in_data holds a valid byte
in_data  input  8  stream byte
in_ready  output  1  loader accepts a byte this cycle
imem_we  output  1  instruction memory write enable, one-cycle pulse per word
imem_waddr  output  ADDR_W  byte address of the word being written
imem_wdata  output  32  assembled instruction word
cpu_hold  output  1  high while image is not yet valid; CPU must not fetch
done  output  1  image loaded and checksum matched
error  output  1  bad word count or checksum mismatch
words_written  output  ADDR_W-1  number of words written in the current load

Behaviour:
- A byte transfers on a rising clk edge with in_valid && in_ready. in_ready is decoded from state only, never from in_valid. It is 1 in COUNT, DATA and CHECK, 0 elsewhere and 0 while rst_n=0.
- Stream format: one count byte N, then 4N data bytes, then one checksum byte equal to the XOR of all 4N data bytes.
- Reset (asynchronous, rst_n=0):
  - state=COUNT.
  - imem_we=0, imem_waddr=BASE_ADDR, imem_wdata=0.
  - cpu_hold=1, done=0, error=0, words_written=0.
  - byte index=0, running XOR=0.
  - Reset mid-load abandons the partial image; nothing further is written.
- COUNT: on transfer, latch N.
  - N>MAX_WORDS -> ERROR.
  - N==0 -> CHECK.
  - Otherwise -> DATA.
- DATA:
  - Each accepted byte goes to lane byte_idx: lane 0 = bits[7:0], lane 3 = bits[31:24]. It is also XORed into the running XOR.
  - byte_idx counts 0..3 and wraps.
  - On the transfer that completes lane 3, the next edge sets imem_we=1 with imem_wdata equal to the full word. Latency is one cycle from the fourth byte handshake to the write pulse.
  - imem_waddr = BASE_ADDR + 4*words_written, mod 2^ADDR_W. words_written increments on that same edge.
  - When the N-th word completes -> CHECK. The final write pulse still occurs while in CHECK.
- CHECK: on transfer, compare the byte with the running XOR.
  - Equal -> DONE.
  - Otherwise -> ERROR.
- DONE: done=1, cpu_hold=0 from the first cycle in DONE. Input is ignored.
- ERROR: error=1, cpu_hold=1. Writes already issued are not undone.
- start:
  - In DONE or ERROR: go to COUNT and clear done, error, words_written, byte_idx and the running XOR. imem_waddr returns to BASE_ADDR. cpu_hold=1 on the next cycle.
  - In COUNT, DATA or CHECK: ignored.
- in_valid low in any state: no state change, no write. Stalls of any length between bytes are legal.
- imem_we is never high for two consecutive cycles; at most one write per 4 byte transfers.
- done and error are never both high.

Test Plan:
- Reset release, stream 02, 13 05 00 00 (addi), 93 05 A0 00, checksum 06^... (XOR of the 8 bytes) -> writes 0x00000513@0x00 and 0x00A00593@0x04, words_written=2, done=1, cpu_hold=0.
- Same stream with checksum byte flipped -> both writes occur, error=1, done=0, cpu_hold=1. Then start plus a correct stream -> done=1.
- Count byte 0x41 (65 > MAX_WORDS) -> no write, ERROR after the first byte, in_ready=0 afterwards.
- N=0 followed by checksum 0x00 -> done=1 with no imem_we pulse. With checksum 0x01 instead -> error=1.
- in_valid toggling randomly at about 50% during a 3-word load -> identical writes/addresses 0x00, 0x04, 0x08 to the no-stall case, each imem_we exactly one cycle after the fourth byte handshake.
- rst_n asserted after 6 data bytes of a 2-word load -> outputs return to reset values immediately. A fresh full stream reloads from BASE_ADDR with no stale lanes in the first word.
